// File: rtl/serial_pattern_tx_if.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx_if
//
// Purpose : parallel word handshake into serial_pattern_tx.
//
// Handshake: a word moves across this interface on a rising clock edge
// where in_valid and in_ready are both high. While in_valid is high and
// in_ready is low, the master holds in_data stable and keeps in_valid high.
// in_ready does not depend combinationally on in_valid. in_data is
// meaningful only when in_valid is high.
//
// Signals:
//   in_valid  master -> slave  in_data is offered
//   in_data   master -> slave  payload word, DATA_W bits
//   in_ready  slave  -> master slave can accept a word this cycle
// -----------------------------------------------------------------------------
interface serial_pattern_tx_if #(
    parameter int DATA_W = 8
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
//
// Purpose : serial frame transmitter feeding the overlapping "1001" sequence
//           detector. A parallel word is accepted over a valid/ready handshake
//           and shifted out MSB first, one bit per clock. Each frame may be
//           preceded by the 1001 sync preamble and is always followed by an
//           idle gap of GAP_LEN cycles.
//
// Build option:
//   SERIAL_PATTERN_TX_PREAMBLE_EN  defined   -> every frame starts with 1,0,0,1
//                                  undefined -> accept goes straight to data
//
// Parameters:
//   DATA_W    payload width, 1..32
//   GAP_LEN   idle cycles after each frame, 1..15
//   IDLE_BIT  level on x_out when not transmitting
//
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   synchronous, active-high
//   in_if         slave modport: in_valid, in_data (in), in_ready (out)
//   x_out         out  registered serial bit stream
//   frame_active  out  high while preamble or data bits are on x_out
//   done          out  one-cycle pulse with the last data bit on x_out
//   state_dbg     out  current FSM state encoding
//                      (0 IDLE, 1 PRE, 2 DATA, 3 GAP)
// -----------------------------------------------------------------------------
module serial_pattern_tx #(
    parameter int   DATA_W   = 8,
    parameter int   GAP_LEN  = 2,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    serial_pattern_tx_if.slave  in_if,
    output logic                x_out,
    output logic                frame_active,
    output logic                done,
    output logic [1:0]          state_dbg
);

    // Bit counter is sized for DATA_W-1; keep at least one bit for DATA_W=1.
    localparam int BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CW-1:0] BIT_LAST   = BIT_CW'(DATA_W - 1);
    // Counter value one cycle before the last data bit; done is registered,
    // so it is loaded while the penultimate bit is on x_out.
    localparam logic [BIT_CW-1:0] BIT_PENULT = BIT_CW'((DATA_W > 1) ? DATA_W - 2 : 0);
    localparam logic [3:0]        GAP_LAST   = 4'(GAP_LEN - 1);
    // With a one-bit payload the first data bit is also the last one.
    localparam logic              FIRST_DATA_DONE = (DATA_W == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
        ST_PRE  = 2'd1,
`endif
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shreg;     // next bit to send is always shreg[DATA_W-1]
    logic [BIT_CW-1:0]   bit_cnt;   // index of the data bit currently on x_out
    logic [3:0]          gap_cnt;   // gap cycles already spent, minus one
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    logic [1:0]          pre_cnt;   // preamble bit currently on x_out
`endif

    // Every transition that enters a state also loads x_out with that state's
    // first bit, so x_out always matches the state in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            x_out   <= IDLE_BIT;
            done    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            pre_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    x_out <= IDLE_BIT;
                    done  <= 1'b0;
                    // in_ready is high in IDLE, so in_valid alone means accept.
                    if (in_if.in_valid) begin
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
                        state   <= ST_PRE;
                        pre_cnt <= 2'd0;
                        x_out   <= 1'b1;
                        shreg   <= in_if.in_data;
`else
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        x_out   <= in_if.in_data[DATA_W-1];
                        shreg   <= in_if.in_data << 1;
                        done    <= FIRST_DATA_DONE;
`endif
                    end
                end

`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
                ST_PRE: begin
                    if (pre_cnt == 2'd3) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        x_out   <= shreg[DATA_W-1];
                        shreg   <= shreg << 1;
                        done    <= FIRST_DATA_DONE;
                    end else begin
                        pre_cnt <= pre_cnt + 2'd1;
                        // Preamble is 1,0,0,1: only the fourth bit is a one.
                        x_out   <= (pre_cnt == 2'd2);
                    end
                end
`endif

                ST_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        state   <= ST_GAP;
                        gap_cnt <= 4'd0;
                        x_out   <= IDLE_BIT;
                        done    <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                        x_out   <= shreg[DATA_W-1];
                        shreg   <= shreg << 1;
                        done    <= (bit_cnt == BIT_PENULT);
                    end
                end

                ST_GAP: begin
                    x_out <= IDLE_BIT;
                    done  <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    x_out <= IDLE_BIT;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Pure state decodes; nothing here looks at the inputs.
    assign in_if.in_ready = (state == ST_IDLE);
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    assign frame_active   = (state == ST_PRE) || (state == ST_DATA);
`else
    assign frame_active   = (state == ST_DATA);
`endif
    assign state_dbg      = state;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_tx
//
// Bench for serial_pattern_tx (DATA_W=8, GAP_LEN=2, IDLE_BIT=0) plus a second
// instance with DATA_W=4, GAP_LEN=1 for the narrow-word directed case.
// A frame-level reference model turns every accepted word into the list of
// per-cycle outputs it must produce; a monitor pops one entry per cycle and
// compares. A bench-side 1001 detector watches x_out for the loopback frames.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_pattern_tx;

    localparam int   DATA_W   = 8;
    localparam int   GAP_LEN  = 2;
    localparam logic IDLE_BIT = 1'b0;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam int   P = 4;
`else
    localparam int   P = 0;
`endif
    localparam int   WAIT_LIMIT = 100;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    serial_pattern_tx_if #(.DATA_W(DATA_W)) tb_if ();
    serial_pattern_tx_if #(.DATA_W(4))      tb4_if ();

    logic       x_out, frame_active, done;
    logic [1:0] state_dbg;
    logic       x4, fa4, done4;
    logic [1:0] state4;

    serial_pattern_tx #(.DATA_W(DATA_W), .GAP_LEN(GAP_LEN), .IDLE_BIT(IDLE_BIT)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_if        (tb_if),
        .x_out        (x_out),
        .frame_active (frame_active),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    serial_pattern_tx #(.DATA_W(4), .GAP_LEN(1), .IDLE_BIT(1'b0)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .in_if        (tb4_if),
        .x_out        (x4),
        .frame_active (fa4),
        .done         (done4),
        .state_dbg    (state4)
    );

    // ---------------- scoreboard state ----------------
    // Entry per output cycle: {x_out, frame_active, done, in_ready}
    logic [3:0] exp_q[$];
    logic [7:0] det_exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    logic mon_en   = 1'b0;
    logic cur_idle = 1'b1;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: a frame is optional 1001, the word MSB first with done
    // on the last bit, then GAP_LEN idle cycles; in_ready is low throughout.
    function automatic void push_frame(input logic [DATA_W-1:0] w);
        logic [3:0] pre;
        pre = 4'b1001;
        for (int i = 0; i < P; i++)
            exp_q.push_back({pre[3-i], 1'b1, 1'b0, 1'b0});
        for (int i = DATA_W - 1; i >= 0; i--)
            exp_q.push_back({w[i], 1'b1, (i == 0), 1'b0});
        for (int g = 0; g < GAP_LEN; g++)
            exp_q.push_back({IDLE_BIT, 3'b000});
    endfunction

    // Model update at the edge: reset drops everything; otherwise a word is
    // taken only when the cycle just ending was an idle (ready) cycle.
    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            mon_en <= 1'b1;
        end else if (cur_idle && tb_if.in_valid === 1'b1) begin
            push_frame(tb_if.in_data);
        end
    end

    // Monitor: one expected entry per cycle, idle when the queue is empty.
    always @(negedge clock) begin
        logic [3:0] e;
        if (mon_en) begin
            cyc <= cyc + 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cur_idle <= 1'b0;
            end else begin
                e = {IDLE_BIT, 3'b001};
                cur_idle <= 1'b1;
            end
            check_bit("x_out",        x_out,          e[3]);
            check_bit("frame_active", frame_active,   e[2]);
            check_bit("done",         done,           e[1]);
            check_bit("in_ready",     tb_if.in_ready, e[0]);
        end
    end

    // Loopback: overlapping 1001 detector on x_out; hits completing inside a
    // frame are counted and compared when that frame's done appears.
    logic [2:0] hist    = 3'b000;
    int         det_cnt = 0;
    logic       fa_prev = 1'b0;
    always @(negedge clock) begin
        int cnt_now;
        if (mon_en) begin
            cnt_now = (fa_prev === 1'b1) ? det_cnt : 0;
            if (frame_active === 1'b1 && hist == 3'b100 && x_out === 1'b1)
                cnt_now++;
            det_cnt <= cnt_now;
            fa_prev <= frame_active;
            hist    <= {hist[1:0], x_out};
            if (done === 1'b1 && det_exp_q.size() > 0)
                check_int("detector_hits", cnt_now, int'(det_exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Offer a word and wait (bounded) for the handshake edge.
    task automatic send_word(input logic [DATA_W-1:0] w, input bit hold);
        int t;
        tb_if.in_valid = 1'b1;
        tb_if.in_data  = w;
        t = 0;
        while (tb_if.in_ready !== 1'b1 && t < WAIT_LIMIT) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (t >= WAIT_LIMIT) begin
            n_errors++;
            $display("FAIL accept_timeout at cycle %0d: got no in_ready, expected in_ready within %0d cycles",
                     cyc, WAIT_LIMIT);
            tb_if.in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            if (!hold) tb_if.in_valid = 1'b0;
        end
    endtask

    // Narrow instance: accept 0x9 and compare cycles 1..L4 against fixed tables.
    task automatic run_dut4();
        int         l4;
        logic [9:0] x_tab, d_tab, fa_tab, r_tab;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
        l4     = 10;
        x_tab  = 10'b0010011001;
        d_tab  = 10'b0010000000;
        fa_tab = 10'b0011111111;
        r_tab  = 10'b1000000000;
`else
        l4     = 6;
        x_tab  = 10'b0000001001;
        d_tab  = 10'b0000001000;
        fa_tab = 10'b0000001111;
        r_tab  = 10'b0000100000;
`endif
        check_bit("dut4_in_ready_c0", tb4_if.in_ready, 1'b1);
        tb4_if.in_valid = 1'b1;
        tb4_if.in_data  = 4'h9;
        @(posedge clock);
        #1;
        tb4_if.in_valid = 1'b0;
        tb4_if.in_data  = 4'h6;
        for (int c = 1; c <= l4; c++) begin
            @(negedge clock);
            check_bit("dut4_x_out",        x4,              x_tab[c-1]);
            check_bit("dut4_done",         done4,           d_tab[c-1]);
            check_bit("dut4_frame_active", fa4,             fa_tab[c-1]);
            check_bit("dut4_in_ready",     tb4_if.in_ready, r_tab[c-1]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] loop_words[3];
        logic [7:0] loop_hits[3];
        loop_words[0] = 8'h00; loop_words[1] = 8'h09; loop_words[2] = 8'h99;
        if (P == 4) begin
            loop_hits[0] = 8'd1; loop_hits[1] = 8'd2; loop_hits[2] = 8'd3;
        end else begin
            loop_hits[0] = 8'd0; loop_hits[1] = 8'd1; loop_hits[2] = 8'd2;
        end

        tb_if.in_valid  = 1'b0;
        tb_if.in_data   = '0;
        tb4_if.in_valid = 1'b0;
        tb4_if.in_data  = '0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;

        // Single frame
        send_word(8'hA5, 1'b0);
        idle(20);

        // Back-to-back with in_valid held high
        send_word(8'hFF, 1'b1);
        send_word(8'h00, 1'b0);
        idle(20);

        // Reset in cycle 7, new word offered alongside it and again in cycle 8
        send_word(8'h3C, 1'b0);
        idle(7);
        reset          = 1'b1;
        tb_if.in_valid = 1'b1;
        tb_if.in_data  = 8'h5A;
        @(negedge clock);
        reset = 1'b0;
        send_word(8'h5A, 1'b0);
        idle(20);

        // Backpressure noise on in_valid/in_data during a frame
        send_word(8'hC3, 1'b0);
        repeat (10) begin
            @(negedge clock);
            tb_if.in_valid = 1'($urandom_range(0, 1));
            tb_if.in_data  = 8'($urandom);
        end
        tb_if.in_valid = 1'b0;
        idle(20);

        // Loopback through the 1001 detector
        for (int k = 0; k < 3; k++) begin
            det_exp_q.push_back(loop_hits[k]);
            send_word(loop_words[k], 1'b0);
            idle(P + DATA_W + GAP_LEN + 4);
        end

        // Random traffic with occasional resets
        repeat (400) begin
            @(negedge clock);
            reset          = ($urandom_range(0, 79) == 0);
            tb_if.in_valid = ($urandom_range(0, 2) != 0);
            tb_if.in_data  = 8'($urandom);
        end
        reset          = 1'b0;
        tb_if.in_valid = 1'b0;
        idle(30);

        run_dut4();
        idle(5);

        check_int("scoreboard_drained", exp_q.size(), 0);
        check_int("detector_queue_drained", det_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial frame transmitter that drives the single-bit `x` stream consumed by the design's overlapping `1001` Mealy sequence detector. It accepts a parallel word over a valid/ready handshake and emits it one bit per clock, MSB first. Each frame is optionally preceded by the `1001` sync preamble and always followed by an idle gap. It is the source end of the detector's serial link and doubles as a directed stimulus generator for it.

## Interface
- `DATA_W`, default 8: payload width in bits; legal range 1..32.
- `GAP_LEN`, default 2: idle cycles after each frame; legal range 1..15.
- `IDLE_BIT`, default 1'b0: level driven on `x_out` when not transmitting.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` is offered.
- `in_data`  in  DATA_W  payload word; sampled only on the accept cycle.
- `in_ready`  out  1  block can accept a word (state IDLE).
- `x_out`  out  1  registered serial bit stream.
- `frame_active`  out  1  high while preamble or data bits are on `x_out`.
- `done`  out  1  one-cycle pulse in the cycle `x_out` carries the last data bit.

## Operation
- States: IDLE, PRE, DATA, GAP. All outputs are driven from registers or from a state decode only; no combinational path from inputs to outputs.
- IDLE: `in_ready=1` and `x_out=IDLE_BIT`. Accept occurs when `in_valid & in_ready` at a rising edge.
  - On accept, latch `in_data` into the shift register.
  - Go to PRE (macro defined) or DATA (macro undefined).
  - Load `x_out` with the first bit of the next state.
- PRE: 4 cycles, `x_out` = 1, 0, 0, 1, tracked by a 2-bit counter. Then go to DATA.
- DATA: DATA_W cycles, `x_out` = `in_data[DATA_W-1]` down to `in_data[0]`, tracked by a bit counter.
  - `done=1` in the cycle carrying bit 0.
  - Then go to GAP.
- GAP: GAP_LEN cycles with `x_out=IDLE_BIT`, tracked by a counter. Then go to IDLE.
- `frame_active` = (state is PRE or DATA).
- `in_valid` while `in_ready=0` is ignored; the upstream holds the word.
- Changes to `in_data` after accept have no effect on the frame in flight.
- Counters are sized to their maximum value and reload on every state entry.
- Bit-counter wrap-around is never used as a terminal condition; termination is an explicit compare.

## Timing
- Reset values: state IDLE, `x_out=IDLE_BIT`, `in_ready=1` (decoded from IDLE), `frame_active=0`, `done=0`, counters 0.
- Reset mid-frame: on the next edge the block is in IDLE and `x_out=IDLE_BIT`.
  - The in-flight word is dropped with no `done` pulse.
  - Reset has priority over an accept in the same cycle.
- Latency: accept edge at the end of cycle 0 → first frame bit on `x_out` in cycle 1.
- Frame length from cycle 1: P + DATA_W + GAP_LEN cycles, where P = 4 with the macro defined and 0 without.
- `in_ready` rises in cycle P + DATA_W + GAP_LEN + 1. Minimum accept-to-accept spacing is P + DATA_W + GAP_LEN + 1 cycles.
- Holding `in_valid` high continuously produces back-to-back frames at that spacing, with exactly GAP_LEN+1 cycles at IDLE_BIT between frames.
- `done` is high for exactly 1 cycle per completed frame. It coincides with `frame_active=1`; `frame_active` falls on the following cycle.

## Configuration
- `SERIAL_PATTERN_TX_PREAMBLE_EN` defined:
  - Every frame starts with the 4-bit `1001` preamble (state PRE present).
  - P = 4.
- Undefined:
  - PRE state and its counter are compiled out.
  - An accept goes directly to DATA; P = 0.
  - All other behaviour is unchanged.

## Test plan
All scenarios use DATA_W=8, GAP_LEN=2, IDLE_BIT=0 unless stated otherwise.
- Single frame (macro on): accept 0xA5 in cycle 0 →
  - `x_out` cycles 1–14 = 1,0,0,1,1,0,1,0,0,1,0,1,0,0.
  - `done` high in cycle 12 only; `frame_active` high in cycles 1–12.
  - `in_ready` low in cycles 1–14 and high again in cycle 15.
- Back-to-back: `in_valid` held high with 0xFF then 0x00 →
  - Second accept in cycle 15.
  - Second frame's preamble on `x_out` in cycles 16–19.
  - Exactly 3 cycles of 0 between the last data bit of frame 1 and the preamble of frame 2.
- Reset mid-frame: accept 0x3C, assert `reset` in cycle 7 →
  - Cycle 8: `x_out=0`, `in_ready=1`, `frame_active=0`.
  - No `done` pulse.
  - A new accept in cycle 8 yields a clean frame from cycle 9.
- Backpressure: toggle `in_valid` and `in_data` randomly during a frame → frame bits unchanged, no extra accepts.
- Loopback: drive a bench model of the overlapping `1001` detector from `x_out` with payloads 0x00, 0x09, 0x99 →
  - The detector pulses exactly 1, 2 and 3 times per frame respectively.
  - Hand-verify these counts, including overlaps between the preamble and the data bits, before freezing them as expected values.
- Macro off, DATA_W=4, GAP_LEN=1: accept 0x9 →
  - `x_out` cycles 1–5 = 1,0,0,1,0.
  - `done` in cycle 4; `in_ready` high in cycle 6.
